// File: rtl/stream_demux_pkg.sv
`default_nettype none
// ============================================================================
// Module  : stream_demux_pkg
// Purpose : Shared state encoding, counter width and parameter legality check
//           for the stream_demux 1-to-N packet demultiplexer.
// Revision: 1.0 - initial release
// ============================================================================
package stream_demux_pkg;

  localparam int DROP_CNT_W = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_PKT  = 2'd1;
  localparam state_t ST_DROP = 2'd2;

  function automatic bit sel_w_legal(input int n_out, input int sel_w);
    return (n_out >= 2) && (sel_w >= 1) && (sel_w < 31) && ((1 << sel_w) >= n_out);
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_demux_slot.sv
`default_nettype none
// ============================================================================
// Module  : stream_demux_slot
// Purpose : One-entry valid/ready holding register for data, last and dest;
//           accepts a new beat in the same cycle the held one drains.
// Revision: 1.0 - initial release
// ============================================================================
module stream_demux_slot
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEST_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic [DEST_W-1:0] in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [DEST_W-1:0] out_dest
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic              last_q,  last_d;
  logic [DEST_W-1:0] dest_q,  dest_d;
  logic              load;

  always_comb begin
    in_ready = !valid_q || out_ready;
    load     = in_valid && in_ready;
    valid_d  = valid_q;
    data_d   = data_q;
    last_d   = last_q;
    dest_d   = dest_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = in_data;
      last_d  = in_last;
      dest_d  = in_dest;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      dest_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      dest_q  <= dest_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q;
  assign out_dest  = dest_q;

endmodule
`default_nettype wire

// File: rtl/stream_demux.sv
`default_nettype none
// ============================================================================
// Module  : stream_demux
// Purpose : 1-to-N packet stream demultiplexer with a registered output stage.
//           Optional feature macro STREAM_DEMUX_DROP_EN drops packets whose
//           first-beat select is out of range and counts them.
// Revision: 1.0 - initial release
// ============================================================================
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int N_OUT  = 2,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic [SEL_W-1:0]  s_sel,
  output logic [N_OUT-1:0]  m_valid,
  input  logic [N_OUT-1:0]  m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy
`ifdef STREAM_DEMUX_DROP_EN
  ,
  output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

  if (!sel_w_legal(N_OUT, SEL_W)) begin : g_bad_param
    $error("stream_demux: SEL_W too narrow for N_OUT, or N_OUT < 2");
  end

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   pkt_dest_q, pkt_dest_d;
  logic               sel_oor;
  logic [SEL_W-1:0]   first_dest;
  logic               drop_now;
  logic               accept;
  logic               slot_in_valid;
  logic               slot_in_ready;
  logic [SEL_W-1:0]   slot_in_dest;
  logic               slot_out_valid;
  logic               slot_out_ready;
  logic [SEL_W-1:0]   slot_out_dest;

  always_comb begin
    sel_oor    = (int'(s_sel) >= N_OUT);
    first_dest = sel_oor ? '0 : s_sel;
`ifdef STREAM_DEMUX_DROP_EN
    drop_now   = (state_q == ST_DROP) || ((state_q == ST_IDLE) && sel_oor);
`else
    drop_now   = 1'b0;
`endif
    s_ready       = drop_now || slot_in_ready;
    slot_in_valid = s_valid && !drop_now;
    accept        = s_valid && s_ready;
    // Only the first beat looks at s_sel; later beats follow the locked dest.
    slot_in_dest  = (state_q == ST_IDLE) ? first_dest : pkt_dest_q;
  end

  always_comb begin
    state_d    = state_q;
    pkt_dest_d = pkt_dest_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
`ifdef STREAM_DEMUX_DROP_EN
          if (sel_oor) begin
            if (!s_last) state_d = ST_DROP;
          end else begin
            pkt_dest_d = first_dest;
            if (!s_last) state_d = ST_PKT;
          end
`else
          pkt_dest_d = first_dest;
          if (!s_last) state_d = ST_PKT;
`endif
        end
      end
      ST_PKT: begin
        if (accept && s_last) state_d = ST_IDLE;
      end
`ifdef STREAM_DEMUX_DROP_EN
      ST_DROP: begin
        if (accept && s_last) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pkt_dest_q <= '0;
    end else begin
      state_q    <= state_d;
      pkt_dest_q <= pkt_dest_d;
    end
  end

  assign busy = (state_q != ST_IDLE);

  stream_demux_slot #(
    .DATA_W (DATA_W),
    .DEST_W (SEL_W)
  ) u_slot (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (slot_in_valid),
    .in_ready  (slot_in_ready),
    .in_data   (s_data),
    .in_last   (s_last),
    .in_dest   (slot_in_dest),
    .out_valid (slot_out_valid),
    .out_ready (slot_out_ready),
    .out_data  (m_data),
    .out_last  (m_last),
    .out_dest  (slot_out_dest)
  );

  // Non-selected outputs' ready lines have no influence on the slot.
  always_comb begin
    slot_out_ready = 1'b0;
    for (int k = 0; k < N_OUT; k++) begin
      if (slot_out_dest == SEL_W'(k)) slot_out_ready = m_ready[k];
    end
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_mvalid
    assign m_valid[k] = slot_out_valid && (slot_out_dest == SEL_W'(k));
  end

`ifdef STREAM_DEMUX_DROP_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if ((state_q == ST_IDLE) && accept && sel_oor && (drop_cnt_q != '1))
      drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_demux.sv
`default_nettype none
// ============================================================================
// Module  : tb_stream_demux
// Purpose : Self-checking bench for stream_demux (N_OUT=4 main instance plus
//           an N_OUT=3 instance for out-of-range select handling).
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_stream_demux;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Main instance: N_OUT=4
  logic       s_valid = 1'b0, s_last = 1'b0, s_ready;
  logic [7:0] s_data = '0, m_data;
  logic [1:0] s_sel = '0;
  logic [3:0] m_valid, m_ready = '0;
  logic       m_last, busy;

  // Secondary instance: N_OUT=3
  logic       s3_valid = 1'b0, s3_last = 1'b0, s3_ready;
  logic [7:0] s3_data = '0, m3_data;
  logic [1:0] s3_sel = '0;
  logic [2:0] m3_valid, m3_ready = '0;
  logic       m3_last, busy3;
`ifdef STREAM_DEMUX_DROP_EN
  logic [15:0] drop_cnt, drop_cnt3;
`endif

  stream_demux #(.N_OUT(4), .DATA_W(8), .SEL_W(2)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last), .s_sel(s_sel),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .busy(busy)
`ifdef STREAM_DEMUX_DROP_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  stream_demux #(.N_OUT(3), .DATA_W(8), .SEL_W(2)) dut3 (
    .clk(clk), .rst(rst),
    .s_valid(s3_valid), .s_ready(s3_ready), .s_data(s3_data), .s_last(s3_last), .s_sel(s3_sel),
    .m_valid(m3_valid), .m_ready(m3_ready), .m_data(m3_data), .m_last(m3_last), .busy(busy3)
`ifdef STREAM_DEMUX_DROP_EN
    , .drop_cnt(drop_cnt3)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: beats in flight to the outputs, plus open-packet tracking.
  typedef struct packed {
    logic [1:0] dest;
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t      exp_q[$];
  logic       in_pkt   = 1'b0;
  logic [1:0] pkt_dest = '0;

  task automatic step(input logic v, input logic [7:0] d, input logic l,
                      input logic [1:0] sel, input logic [3:0] mr);
    logic [3:0] exp_valid;
    logic       exp_sready;
    logic [1:0] dst;
    @(negedge clk);
    s_valid = v; s_data = d; s_last = l; s_sel = sel; m_ready = mr;
    #1;
    exp_valid  = (exp_q.size() != 0) ? (4'b0001 << exp_q[0].dest) : 4'b0000;
    exp_sready = (exp_q.size() == 0) || mr[exp_q[0].dest];
    check("m_valid", 32'(m_valid), 32'(exp_valid));
    check("s_ready", 32'(s_ready), 32'(exp_sready));
    check("busy",    32'(busy),    32'(in_pkt));
    if (exp_q.size() != 0) begin
      check("m_data", 32'(m_data), 32'(exp_q[0].data));
      check("m_last", 32'(m_last), 32'(exp_q[0].last));
      if (mr[exp_q[0].dest]) void'(exp_q.pop_front());
    end
    if (v && exp_sready) begin
      dst = in_pkt ? pkt_dest : sel;
      exp_q.push_back('{dest: dst, data: d, last: l});
      if (!in_pkt) pkt_dest = sel;
      in_pkt = !l;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; s_valid = 1'b0; s3_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_m_valid", 32'(m_valid), 32'h0);
    check("rst_busy",    32'(busy),    32'h0);
    check("rst_m_data",  32'(m_data),  32'h0);
    check("rst_m_last",  32'(m_last),  32'h0);
    rst = 1'b0;
    exp_q.delete();
    in_pkt = 1'b0;
    pkt_dest = '0;
  endtask

  initial begin
    do_reset();

    // Reset mid-packet: open packet to output 3, held beat must vanish
    step(1, 8'h11, 0, 2'd3, 4'hF);
    step(1, 8'h12, 0, 2'd0, 4'h0);
    do_reset();
    step(1, 8'h21, 1, 2'd1, 4'hF);
    step(0, 8'h00, 0, 2'd0, 4'hF);

    // Three-beat packet to output 2; select changes mid-packet are ignored
    step(1, 8'hA1, 0, 2'd2, 4'hF);
    step(1, 8'hA2, 0, 2'd0, 4'hF);
    step(1, 8'hA3, 1, 2'd3, 4'hF);
    step(0, 8'h00, 0, 2'd0, 4'hF);
    step(0, 8'h00, 0, 2'd0, 4'hF);

    // Back-to-back packets to different outputs with no bubble
    step(1, 8'hB1, 1, 2'd1, 4'hF);
    step(1, 8'hC1, 0, 2'd3, 4'hF);
    step(1, 8'hC2, 1, 2'd0, 4'hF);
    step(0, 8'h00, 0, 2'd0, 4'hF);
    step(0, 8'h00, 0, 2'd0, 4'hF);

    // Backpressure on output 0 only
    step(1, 8'hD1, 0, 2'd0, 4'hE);
    step(1, 8'hD2, 0, 2'd0, 4'hE);
    step(1, 8'hD2, 0, 2'd0, 4'hE);
    step(1, 8'hD2, 0, 2'd0, 4'hE);
    step(1, 8'hD2, 1, 2'd0, 4'hF);
    step(0, 8'h00, 0, 2'd0, 4'hF);
    step(0, 8'h00, 0, 2'd0, 4'hF);

    // Randomised traffic with random per-output backpressure
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] mr;
      for (int k = 0; k < 4; k++) mr[k] = ($urandom_range(0, 3) != 0);
      step(($urandom_range(0, 9) < 7), 8'($urandom), ($urandom_range(0, 3) == 0),
           2'($urandom_range(0, 3)), mr);
    end
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 2'd0, 4'hF);
    check("drain_empty", 32'(exp_q.size()), 32'h0);

    // Out-of-range select on the N_OUT=3 instance
    do_reset();
    m3_ready = 3'b111;
    @(negedge clk);
    s3_valid = 1'b1; s3_data = 8'h5A; s3_last = 1'b0; s3_sel = 2'd3;
    #1;
    check("oor_s_ready0", 32'(s3_ready), 32'h1);
    @(negedge clk);
    s3_data = 8'h5B; s3_last = 1'b1; s3_sel = 2'd1;
    #1;
    check("oor_s_ready1", 32'(s3_ready), 32'h1);
    check("oor_busy",     32'(busy3),    32'h1);
`ifdef STREAM_DEMUX_DROP_EN
    check("drop_m_valid0", 32'(m3_valid), 32'h0);
    check("drop_cnt1",     32'(drop_cnt3), 32'h1);
`else
    check("oor_m_valid0", 32'(m3_valid), 32'h1);
    check("oor_m_data0",  32'(m3_data),  32'h5A);
`endif
    @(negedge clk);
    s3_valid = 1'b0;
    #1;
    check("oor_busy_end", 32'(busy3), 32'h0);
`ifdef STREAM_DEMUX_DROP_EN
    check("drop_m_valid1", 32'(m3_valid), 32'h0);
    check("drop_cnt_hold", 32'(drop_cnt3), 32'h1);
    // Single-beat drops up to saturation and one beyond
    @(negedge clk);
    s3_valid = 1'b1; s3_last = 1'b1; s3_sel = 2'd3;
    repeat (65535) @(negedge clk);
    s3_valid = 1'b0;
    #1;
    check("drop_cnt_sat", 32'(drop_cnt3), 32'hFFFF);
    check("drop_busy",    32'(busy3),     32'h0);
`else
    check("oor_m_valid1", 32'(m3_valid), 32'h1);
    check("oor_m_data1",  32'(m3_data),  32'h5B);
    check("oor_m_last1",  32'(m3_last),  32'h1);
`endif
    // In-range select on the N_OUT=3 instance after the out-of-range packet
    @(negedge clk);
    s3_valid = 1'b1; s3_data = 8'h77; s3_last = 1'b1; s3_sel = 2'd2;
    @(negedge clk);
    s3_valid = 1'b0;
    #1;
    check("n3_m_valid2", 32'(m3_valid), 32'h4);
    check("n3_m_data2",  32'(m3_data),  32'h77);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
